// File: rtl/cnt_sample_fifo.sv
// Sample FIFO behind the gated pulse counter: tags each window count with a
// wrapping sequence number and streams {seq, sample} out on an Avalon-ST source.
module cnt_sample_fifo #(
    parameter int DATA_W = 32,
    parameter int SEQ_W  = 16,
    parameter int DEPTH  = 16,
    parameter int LVL_W  = 5
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clr,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_strobe,
    output logic [SEQ_W+DATA_W-1:0] st_data,
    output logic                    st_valid,
    input  logic                    st_ready,
    output logic [LVL_W-1:0]        fill_level,
    output logic [15:0]             drop_cnt,
    output logic                    ovf
);

    localparam int PTR_W = LVL_W - 1;
    localparam int ENT_W = SEQ_W + DATA_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [SEQ_W-1:0] seq;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // Handshake: a head entry transfers on any edge where st_valid & st_ready;
    // st_valid never drops and st_data never changes until that transfer happens.
    assign full = (fill_level == LVL_W'(DEPTH));
    assign pop  = st_valid & st_ready & ~clr;
    assign push = in_strobe & (~full | pop) & ~clr;
    assign drop = in_strobe & full & ~pop & ~clr;

    // Head is read straight from the registered memory; empty reads stay masked.
    assign st_valid = (fill_level != '0);
    assign st_data  = st_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {seq, in_data};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_level <= '0;
            seq        <= '0;
            drop_cnt   <= '0;
            ovf        <= 1'b0;
        end else if (clr) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_level <= '0;
            seq        <= '0;
            drop_cnt   <= '0;
            ovf        <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fill_level <= fill_level + LVL_W'(1);
            end else if (pop && !push) begin
                fill_level <= fill_level - LVL_W'(1);
            end
            // Dropped samples still consume a tag so the reader sees the gap.
            if (in_strobe) begin
                seq <= seq + SEQ_W'(1);
            end
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cnt_sample_fifo.sv
// Bench for cnt_sample_fifo: directed scenarios plus random traffic, all checked
// against a queue-based model of the tagged sample stream.
module tb_cnt_sample_fifo;

    localparam int DATA_W = 32;
    localparam int SEQ_W  = 16;
    localparam int DEPTH  = 16;
    localparam int LVL_W  = 5;
    localparam int ENT_W  = SEQ_W + DATA_W;
    localparam int VEC_W  = 1 + ENT_W + LVL_W + 16 + 1;

    logic              CLK;
    logic              RST;
    logic              clr;
    logic [DATA_W-1:0] in_data;
    logic              in_strobe;
    logic [ENT_W-1:0]  st_data;
    logic              st_valid;
    logic              st_ready;
    logic [LVL_W-1:0]  fill_level;
    logic [15:0]       drop_cnt;
    logic              ovf;

    int total = 0;
    int bad   = 0;

    logic [ENT_W-1:0] exp_q[$];
    logic [SEQ_W-1:0] m_seq;
    logic [15:0]      m_drops;
    logic             m_ovf;

    cnt_sample_fifo #(
        .DATA_W(DATA_W), .SEQ_W(SEQ_W), .DEPTH(DEPTH), .LVL_W(LVL_W)
    ) dut (
        .CLK(CLK), .RST(RST), .clr(clr), .in_data(in_data), .in_strobe(in_strobe),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .fill_level(fill_level), .drop_cnt(drop_cnt), .ovf(ovf)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // reference model
    task automatic model_reset();
        exp_q.delete();
        m_seq   = '0;
        m_drops = '0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic [DATA_W-1:0] d,
                              input logic r, input logic c);
        logic was_full;
        logic popped;
        if (c) begin
            model_reset();
        end else begin
            was_full = (exp_q.size() == DEPTH);
            popped   = (exp_q.size() != 0) && r;
            if (popped) void'(exp_q.pop_front());
            if (s) begin
                if (!was_full || popped) begin
                    exp_q.push_back({m_seq, d});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                end
                m_seq = m_seq + 16'd1;
            end
        end
    endtask

    function automatic logic [VEC_W-1:0] exp_vec();
        logic [ENT_W-1:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        return {exp_q.size() != 0, head, LVL_W'(exp_q.size()), m_drops, m_ovf};
    endfunction

    function automatic logic [VEC_W-1:0] dut_vec();
        return {st_valid, st_data, fill_level, drop_cnt, ovf};
    endfunction

    // driver: called at a negedge, returns at the following negedge
    task automatic tick(input logic s, input logic [DATA_W-1:0] d,
                        input logic r, input logic c);
        in_strobe = s;
        in_data   = d;
        st_ready  = r;
        clr       = c;
        @(posedge CLK);
        model_step(s, d, r, c);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        total++;
        if (dut_vec() !== '0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=0", dut_vec());
        end
        RST = 1'b1;
        @(negedge CLK);
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        tick(1'b1, 32'h0000_00A5, 1'b1, 1'b0);
        total++;
        if (st_valid !== 1'b1 || st_data !== {16'h0000, 32'h0000_00A5}) begin
            bad++;
            $display("FAIL single_head got=%b/%h exp=1/%h", st_valid, st_data,
                     {16'h0000, 32'h0000_00A5});
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        total++;
        if (st_valid !== 1'b0 || fill_level !== 5'd0) begin
            bad++;
            $display("FAIL single_empty got=%b/%0d exp=0/0", st_valid, fill_level);
        end
    endtask

    task automatic test_fill_hold();
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 16; i++) tick(1'b1, 32'(i), 1'b0, 1'b0);
        total++;
        if (fill_level !== 5'd16 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL fill_full got=%0d/%b exp=16/0", fill_level, ovf);
        end
        tick(1'b1, 32'd17, 1'b0, 1'b0);
        tick(1'b1, 32'd18, 1'b0, 1'b0);
        total++;
        if (drop_cnt !== 16'd2 || ovf !== 1'b1 || fill_level !== 5'd16) begin
            bad++;
            $display("FAIL fill_drop got=%0d/%b/%0d exp=2/1/16", drop_cnt, ovf, fill_level);
        end
        for (int i = 1; i <= 16; i++) begin
            total++;
            if (st_valid !== 1'b1 || st_data !== {16'(i - 1), 32'(i)}) begin
                bad++;
                $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, st_valid, st_data,
                         {16'(i - 1), 32'(i)});
            end
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        end
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL drain_end got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 16; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        tick(1'b1, 32'hF00D_0001, 1'b1, 1'b0);
        total++;
        if (fill_level !== 5'd16 || drop_cnt !== m_drops || dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL full_pop got=%h exp=%h", dut_vec(), exp_vec());
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL full_pop_drain got=%h exp=%h", dut_vec(), exp_vec());
            end
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] rdy;
        rdy = 6'b101001;
        for (int i = 0; i < 3; i++) tick(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 32'h0, rdy[i], 1'b0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL backpressure_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clr();
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
        total++;
        if (fill_level !== 5'd5 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL clr_setup got=%0d/%b exp=5/1", fill_level, ovf);
        end
        tick(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        total++;
        if (fill_level !== 5'd0 || st_valid !== 1'b0 || drop_cnt !== 16'd0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL clr_flush got=%0d/%b/%0d/%b exp=0/0/0/0",
                     fill_level, st_valid, drop_cnt, ovf);
        end
        tick(1'b1, 32'h0000_0077, 1'b0, 1'b0);
        total++;
        if (st_data !== {16'h0000, 32'h0000_0077}) begin
            bad++;
            $display("FAIL clr_seq0 got=%h exp=%h", st_data, {16'h0000, 32'h0000_0077});
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
        in_strobe = 1'b0;
        st_ready  = 1'b1;
        #2 RST = 1'b0;
        #1;
        total++;
        if (dut_vec() !== '0) begin
            bad++;
            $display("FAIL async_reset got=%h exp=0", dut_vec());
        end
        model_reset();
        st_ready = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        test_single();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'(($urandom_range(0, 3)) != 0), $urandom,
                 (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 59) == 0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        RST       = 1'b0;
        clr       = 1'b0;
        in_data   = '0;
        in_strobe = 1'b0;
        st_ready  = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        test_reset();
        test_single();
        test_fill_hold();
        test_full_pop();
        test_backpressure();
        test_clr();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnt_sample_fifo.md
Name: cnt_sample_fifo

Overview:
Downstream stage of the gated pulse counter. Captures each window-count sample on the counter's one-cycle ready strobe and tags it with a wrapping sequence number. Buffers the tagged samples in a first-word-fall-through FIFO and presents them on an Avalon-ST source, so the HPS-side DMA/reader can drain them without losing windows. Drops are counted, never silent.

Parameters:
DATA_W, 32, width of count sample from the counter stage
SEQ_W, 16, width of sequence tag prepended to each sample
DEPTH, 16, FIFO entries; power of 2, >= 2
LVL_W, 5, fill-level width; must equal log2(DEPTH)+1

Ports:
CLK  in  1  system clock, all logic rising-edge
RST  in  1  asynchronous, active-low reset (0 = reset asserted); deasserted synchronously by the system
clr  in  1  synchronous flush; pulse shares its source with the counter's window-reload write
in_data  in  DATA_W  count sample from the counter stage
in_strobe  in  1  one-cycle sample-valid from the counter stage (its ready)
st_data  out  SEQ_W+DATA_W  {seq, sample} at FIFO head
st_valid  out  1  head entry valid
st_ready  in  1  sink accepts head this cycle
fill_level  out  LVL_W  entries currently stored, 0..DEPTH
drop_cnt  out  16  samples discarded because FIFO full; saturates at 16'hFFFF
ovf  out  1  sticky: set on first drop, cleared only by clr or RST

Behaviour:
- Reset (RST=0, async): read pointer, write pointer, fill_level, seq counter, drop_cnt and ovf all 0. st_valid = 0. st_data = 0. Memory contents are don't-care.
- pop = st_valid & st_ready. push = in_strobe & (fill_level != DEPTH | pop). The full-with-simultaneous-pop case is accepted: the slot frees the same edge.
- clr=1 (sync) has priority over push and pop in the same cycle:
  - pointers, fill_level, seq, drop_cnt, ovf -> 0; st_valid -> 0 next cycle.
  - A strobe coinciding with clr is discarded, not counted as a drop, and does not advance seq.
- Sequence tag:
  - Every in_strobe outside clr increments seq by 1 mod 2^SEQ_W, including dropped samples, so gaps are visible downstream.
  - The stored tag is the pre-increment seq value. The first sample after reset/clr carries seq 0.
- Drop: in_strobe & fill_level==DEPTH & !pop.
  - drop_cnt += 1, saturating at 16'hFFFF.
  - ovf <= 1.
  - FIFO contents are unchanged (newest sample dropped).
- Latency:
  - Strobe at edge N into an empty FIFO gives st_valid=1 and st_data={tag, in_data@N} in cycle N+1 (visible after edge N).
  - No combinational path from in_strobe or in_data to st_*.
- Head behaviour:
  - st_data and st_valid stay stable while st_valid & !st_ready (Avalon-ST hold rule).
  - After pop at edge N, the next entry (if any) is presented in cycle N+1.
  - With continuous st_ready the FIFO sustains one pop per cycle.
- fill_level is registered:
  - push & !pop -> +1
  - pop & !push -> -1
  - push & pop -> unchanged
- Pointers are log2(DEPTH) bits and wrap naturally at DEPTH.
- st_data is registered or sourced from registered memory through the read pointer only. Reads of empty memory are never exposed (st_valid=0 gates).
- Reset mid-stream: all state is discarded immediately on RST fall, including an in-flight pop. No partial transfer is completed.
- in_strobe back-to-back on consecutive cycles is legal and supported at full rate.

Test Plan:
1. Single sample: RST release, in_strobe with in_data=0x0000_00A5, st_ready=1 -> next cycle st_valid=1, st_data={16'h0000, 32'hA5}. Following cycle st_valid=0; fill_level returns 0.
2. Fill and hold: st_ready=0, 16 strobes with data 1..16 -> fill_level=16, ovf=0. A 17th and 18th strobe -> drop_cnt=2, ovf=1. Then st_ready=1 drains data 1..16 with seq 0..15, one per cycle.
3. Full + pop same cycle: FIFO full, strobe and pop coincide -> sample accepted, fill_level stays 16, drop_cnt unchanged, tail entry carries the next seq.
4. Backpressure stability: 3 entries queued, st_ready toggled 1,0,0,1,0,1 -> st_data is constant across each stall; entries come out in order with no duplicates or skips.
5. clr priority: clr coincident with strobe and pop while 5 entries are stored and ovf=1 -> next cycle fill_level=0, st_valid=0, drop_cnt=0, ovf=0. The next strobe is tagged seq 0.
6. Async reset mid-drain: drop RST between clock edges with st_valid=1 -> outputs go to 0 immediately without a clock edge. After release, behaviour matches scenario 1.
